chebyshev_sequencer: RTL
========================

// Module: chebyshev_sequencer
// PURPOSE
//  Control/feed side of the sequential Chebyshev/Horner datapath. Holds the polynomial coefficients
//  and accepts operand x over a valid/ready handshake. Issues one coefficient per Horner step,
//  highest degree first, on comp_data/comp_coeff, then reads the finished result back from comp_result.
//  Returns y over a valid/ready handshake. Sits between the stream source/sink and the computation datapath.
// PARAMETERS
//  WORD_LENGTH   16  width of x, comp_data, comp_result, y_data
//  COEFF_LENGTH  16  width of each coefficient (signed two's complement)
//  DEGREE        3   polynomial degree; DEGREE+1 coefficients stored, max 4 (datapath WIDENING=2)
//  ADDR_WIDTH    2   coefficient address width, = ceil(log2(DEGREE+1))
//  STEP_LATENCY  2   clock cycles the datapath needs per Horner step (mult+adder pipeline), >=1
// PORTS
//  clock          in   1             rising-edge clock
//  resetn         in   1             asynchronous active-low reset
//  coeff_wr_en    in   1             coefficient write strobe
//  coeff_wr_addr  in   ADDR_WIDTH    coefficient index k (c_k multiplies T_k)
//  coeff_wr_data  in   COEFF_LENGTH  coefficient value
//  coeff_wr_err   out  1             1-cycle pulse: write rejected (busy or addr>DEGREE)
//  x_valid        in   1             operand valid
//  x_ready        out  1             sequencer can accept operand
//  x_data         in   WORD_LENGTH   operand x
//  comp_data      out  WORD_LENGTH   x held to datapath for whole evaluation
//  comp_coeff     out  COEFF_LENGTH  coefficient for current step
//  comp_init      out  1             1 during first step: datapath feedback treated as zero
//  comp_result    in   WORD_LENGTH   datapath rounded/trimmed accumulator
//  y_valid        out  1             result valid
//  y_ready        in   1             sink accepts result
//  y_data         out  WORD_LENGTH   result p(x)
// BEHAVIOUR
//  Reset: state=IDLE; all coefficients, comp_data, comp_coeff, y_data = 0.
//   x_ready=1; y_valid, comp_init, coeff_wr_err = 0. Takes effect immediately on the resetn falling edge.
//  Reset mid-operation aborts the evaluation; the result is discarded and coefficients are cleared.
//  FSM IDLE -> STEP -> OUT -> IDLE.
//  IDLE: x_ready=1. On x_valid&&x_ready: latch x_data into comp_data, set k=DEGREE, step_cnt=0, go to STEP.
//  STEP: comp_coeff=coef[k], held stable for STEP_LATENCY cycles. comp_init=1 only while k==DEGREE.
//   step_cnt counts 0..STEP_LATENCY-1. At wrap, if k>0 then k<=k-1.
//   If k==0 at wrap: register comp_result into y_data and go to OUT.
//  OUT: y_valid=1 and y_data stable until y_ready. On y_valid&&y_ready go to IDLE.
//   x_ready returns 1 on the next cycle, so there is no same-cycle pass-through.
//  Latency: y_valid rises (DEGREE+1)*STEP_LATENCY+1 cycles after the x accept edge (9 with defaults).
//  Throughput: one evaluation in flight; x_ready=0 in STEP and OUT.
//  Coefficient write (edge with coeff_wr_en=1) succeeds only in IDLE with addr<=DEGREE.
//   Otherwise it is ignored and coeff_wr_err pulses for 1 cycle.
//  Write and x accept on the same IDLE edge: the write lands first. Evaluation uses the new value.
//  y_ready while not OUT: ignored. x_valid while busy: held off by x_ready=0, nothing dropped.
//  No arithmetic performed here; values pass through unmodified (sign preserved, no rounding).
// TESTING
//  Bench models the datapath per step: acc = (comp_init ? 0 : (acc*x)>>>(WORD_LENGTH-1)) + coeff,
//   with the result available STEP_LATENCY cycles after the step starts.
//  T1 reset: resetn=0 mid-STEP -> x_ready=1, y_valid=0, all coefs read as 0 on next evaluation (y=0x0000).
//  T2 const: c0=0x1234, c1..c3=0, x=0x4000 -> y_data=0x1234, y_valid exactly 9 cycles after accept.
//  T3 linear: c1=0x2000, c0=0x0100, others 0, x=0x4000 (0.5) -> y_data=0x1100 per bench model.
//  T4 busy write: write addr=0 during STEP -> coeff_wr_err 1-cycle pulse, c0 unchanged on next run.
//   Write addr=3 in IDLE is accepted with no error.
//  T5 backpressure: y_ready=0 for 5 cycles in OUT -> y_valid held, y_data stable, x_ready=0.
//   x_ready=1 the cycle after the y handshake.
//  T6 same-edge: coeff write c0=0x0001 coincident with x accept -> result uses 0x0001.

Source files
------------

// File: rtl/chebyshev_sequencer.sv
// Chebyshev/Horner sequencer: holds the coefficient table, accepts x, issues one
// coefficient per Horner step (highest degree first) to the datapath and returns
// the datapath's final accumulator as y over a valid/ready handshake.
module chebyshev_sequencer #(
  parameter int WORD_LENGTH  = 16,
  parameter int COEFF_LENGTH = 16,
  parameter int DEGREE       = 3,
  parameter int ADDR_WIDTH   = 2,
  parameter int STEP_LATENCY = 2
) (
  input  logic                           clock,
  input  logic                           resetn,
  input  logic                           coeff_wr_en,
  input  logic [ADDR_WIDTH-1:0]          coeff_wr_addr,
  input  logic signed [COEFF_LENGTH-1:0] coeff_wr_data,
  output logic                           coeff_wr_err,
  input  logic                           x_valid,
  output logic                           x_ready,
  input  logic signed [WORD_LENGTH-1:0]  x_data,
  output logic signed [WORD_LENGTH-1:0]  comp_data,
  output logic signed [COEFF_LENGTH-1:0] comp_coeff,
  output logic                           comp_init,
  input  logic signed [WORD_LENGTH-1:0]  comp_result,
  output logic                           y_valid,
  input  logic                           y_ready,
  output logic signed [WORD_LENGTH-1:0]  y_data
);

  localparam int                    CNT_W    = (STEP_LATENCY > 1) ? $clog2(STEP_LATENCY) : 1;
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(STEP_LATENCY - 1);
  localparam logic [ADDR_WIDTH-1:0] K_TOP    = ADDR_WIDTH'(DEGREE);
  localparam int                    NSLOT    = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_STEP, S_OUT} state_t;

  state_t                         state, state_nxt;
  logic [ADDR_WIDTH-1:0]          k;
  logic [CNT_W-1:0]               step_cnt;
  logic signed [COEFF_LENGTH-1:0] coef [0:DEGREE];
  logic                           x_acc, step_wrap, y_fire, wr_ok;

  // Addresses above DEGREE have no storage; decoded through a mask so the
  // check stays meaningful when the address space is larger than the table.
  function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] a);
    logic [NSLOT-1:0] m;
    for (int i = 0; i < NSLOT; i++) m[i] = (i <= DEGREE);
    return m[a];
  endfunction

  assign wr_ok = coeff_wr_en && (state == S_IDLE) && addr_in_range(coeff_wr_addr);

  // State register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Next-state decode and datapath-facing outputs
  always_comb begin
    state_nxt  = state;
    x_ready    = 1'b0;
    comp_init  = 1'b0;
    comp_coeff = '0;
    x_acc      = 1'b0;
    step_wrap  = 1'b0;
    y_fire     = 1'b0;
    case (state)
      S_IDLE: begin
        x_ready = 1'b1;
        if (x_valid) begin
          x_acc     = 1'b1;
          state_nxt = S_STEP;
        end
      end
      S_STEP: begin
        // coef[k] is read live, so a write landing on the accept edge is used
        comp_coeff = coef[k];
        comp_init  = (k == K_TOP);
        step_wrap  = (step_cnt == CNT_LAST);
        if (step_wrap && (k == '0)) state_nxt = S_OUT;
      end
      S_OUT: begin
        if (y_valid && y_ready) begin
          y_fire    = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Coefficient table and write-reject pulse
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i <= DEGREE; i++) coef[i] <= '0;
      coeff_wr_err <= 1'b0;
    end else begin
      if (wr_ok) coef[coeff_wr_addr] <= coeff_wr_data;
      coeff_wr_err <= coeff_wr_en && !wr_ok;
    end
  end

  // Operand latch, Horner index and per-step cycle counter
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      comp_data <= '0;
      k         <= '0;
      step_cnt  <= '0;
    end else if (x_acc) begin
      comp_data <= x_data;
      k         <= K_TOP;
      step_cnt  <= '0;
    end else if (state == S_STEP) begin
      if (step_wrap) begin
        step_cnt <= '0;
        if (k != '0) k <= k - 1'b1;
      end else begin
        step_cnt <= step_cnt + 1'b1;
      end
    end
  end

  // Result capture: the first OUT cycle gives the datapath time to publish the
  // last step's accumulator, then y is held until the sink takes it
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      y_data  <= '0;
      y_valid <= 1'b0;
    end else if ((state == S_OUT) && !y_valid) begin
      y_data  <= comp_result;
      y_valid <= 1'b1;
    end else if (y_fire) begin
      y_valid <= 1'b0;
    end
  end

endmodule
